// File: rtl/base_unpack_st.sv
// Word-to-base serializer: takes packed base words over valid/ready and emits one base
// per clock, LSB base first. Optional b_last output under `BASE_UNPACK_LAST_EN.
module base_unpack_st #(
  parameter int BASE_W         = 2,
  parameter int BASES_PER_WORD = 8,
  parameter int CNT_W          = $clog2(BASES_PER_WORD+1)
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic                             w_ready,
  input  logic                             w_valid,
  input  logic [BASE_W*BASES_PER_WORD-1:0] w_data,
  input  logic [CNT_W-1:0]                 w_count,
  input  logic                             b_ready,
  output logic                             b_valid,
  output logic [BASE_W-1:0]                b_data
`ifdef BASE_UNPACK_LAST_EN
  ,
  output logic                             b_last
`endif
);

  localparam int WORD_W = BASE_W*BASES_PER_WORD;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t             r_state, w_state_nxt;
  logic [WORD_W-1:0]  r_word_q, w_word_nxt;
  logic [CNT_W-1:0]   r_cnt_q, w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_clamp;
  logic               w_last_base;
  logic               w_load;
  logic               w_b_fire;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_word_q <= '0;
      r_cnt_q  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_word_q <= w_word_nxt;
      r_cnt_q  <= w_cnt_nxt;
    end
  end

  assign w_cnt_clamp = (w_count > CNT_W'(BASES_PER_WORD)) ? CNT_W'(BASES_PER_WORD) : w_count;
  assign w_last_base = (r_state == S_EMIT) && (r_cnt_q == CNT_W'(1));

  // b_ready feeds w_ready combinationally so a new word can land on the last base's cycle.
  assign w_ready  = (r_state == S_IDLE) || (w_last_base && b_ready);
  assign b_valid  = (r_state == S_EMIT);
  assign b_data   = r_word_q[BASE_W-1:0];
  assign w_b_fire = b_valid && b_ready;
  assign w_load   = w_valid && w_ready && (w_count != '0);

`ifdef BASE_UNPACK_LAST_EN
  assign b_last = w_last_base;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word_q;
    w_cnt_nxt   = r_cnt_q;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_word_nxt  = w_data;
          w_cnt_nxt   = w_cnt_clamp;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_b_fire) begin
          if (r_cnt_q > CNT_W'(1)) begin
            w_word_nxt = r_word_q >> BASE_W;
            w_cnt_nxt  = r_cnt_q - CNT_W'(1);
          end else if (w_load) begin
            w_word_nxt = w_data;
            w_cnt_nxt  = w_cnt_clamp;
          end else begin
            w_word_nxt  = r_word_q >> BASE_W;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
